product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 111 +++++++++++
 tb/tb_product_accumulator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums COUNT unsigned 8-bit products into an ACC_W-bit result held under a valid/ready handshake.
// Build option: define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module product_accumulator #(
  parameter int ACC_W = 16,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] LP_COUNT = 8'(COUNT);

  // Returns {carry, next accumulator}; the carry is reported even when the value is clamped.
  function automatic logic [ACC_W:0] f_add(input logic [ACC_W-1:0] acc, input logic [7:0] prod);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod};
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    if (sum[ACC_W]) begin
      sum = {1'b1, {ACC_W{1'b1}}};
    end
`endif
    return sum;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic [7:0]       w_cnt_inc;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             w_xfer;
  logic [ACC_W:0]   w_add;

  assign in_ready     = (r_state != S_HOLD);
  assign out_valid    = (r_state == S_HOLD);
  assign out_sum      = r_acc;
  assign out_overflow = r_ovf;

  assign w_xfer    = in_valid && in_ready;
  assign w_add     = f_add(r_acc, in_product);
  assign w_cnt_inc = r_cnt + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end else if (w_xfer) begin
          w_acc_nxt   = w_add[ACC_W-1:0];
          w_ovf_nxt   = r_ovf | w_add[ACC_W];
          w_cnt_nxt   = w_cnt_inc;
          w_state_nxt = (w_cnt_inc == LP_COUNT) ? S_HOLD : S_ACCUM;
        end
      end
      S_HOLD: begin
        // clear is deliberately ignored here so a finished result is never lost
        if (out_ready) begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_ovf_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 16-bit and a 9-bit instance share stimulus and are checked every cycle
// against a frame-level model built from the list of accepted products.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_product = 8'd0;
  logic        in_ready, out_valid, out_overflow;
  logic [15:0] out_sum;
  logic        in_ready9, out_valid9, out_overflow9;
  logic [8:0]  out_sum9;

  int total = 0;
  int bad   = 0;

  typedef logic [7:0] pq_t[$];
  pq_t m_q;
  bit  m_hold = 1'b0;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(16), .COUNT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_overflow(out_overflow)
  );

  product_accumulator #(.ACC_W(9), .COUNT(4)) dut9 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready9), .in_product(in_product),
    .clear(clear), .out_valid(out_valid9), .out_ready(out_ready), .out_sum(out_sum9),
    .out_overflow(out_overflow9)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Running sum of a product list at width w, one add at a time.
  function automatic void f_sum(input pq_t q, input int w, output longint s, output bit ovf);
    longint mx;
    mx  = (longint'(1) << w) - 1;
    s   = 0;
    ovf = 1'b0;
    foreach (q[i]) begin
      s = s + longint'(q[i]);
      if (s > mx) begin
        ovf = 1'b1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        s = mx;
`else
        s = s - (mx + 1);
`endif
      end
    end
  endfunction

  // Frame model: which products were accepted, and whether a finished frame is waiting.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        m_q.delete();
      end
    end else if (clear) begin
      m_q.delete();
    end else if (in_valid) begin
      m_q.push_back(in_product);
      if (m_q.size() == 4) m_hold = 1'b1;
    end
  end

  always @(negedge clk) begin
    longint s;
    bit     o;
    if (!rst) begin
      f_sum(m_q, 16, s, o);
      chk("cyc_sum", out_sum, s);
      chk("cyc_ovf", out_overflow, o);
      chk("cyc_valid", out_valid, m_hold);
      chk("cyc_ready", in_ready, !m_hold);
      f_sum(m_q, 9, s, o);
      chk("cyc_sum9", out_sum9, s);
      chk("cyc_ovf9", out_overflow9, o);
      chk("cyc_valid9", out_valid9, m_hold);
    end
  end

  task automatic send(input logic [7:0] p);
    in_valid   = 1'b1;
    in_product = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint ms;
    bit     mo;
    pq_t    lit;
    int     n;
    int     cyc;

    lit = '{8'd225, 8'd225, 8'd225, 8'd225};
    f_sum(lit, 16, ms, mo);
    chk("model_900", ms, 900);
    chk("model_900_ovf", mo, 0);
    f_sum(lit, 9, ms, mo);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    chk("model_9b", ms, 511);
`else
    chk("model_9b", ms, 388);
`endif
    chk("model_9b_ovf", mo, 1);

    #12;
    chk("rst_sum", out_sum, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", out_overflow, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) send(8'd225);
    chk("f900_valid", out_valid, 1);
    chk("f900_sum", out_sum, 900);
    chk("f900_ovf", out_overflow, 0);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    chk("w9_sum", out_sum9, 511);
`else
    chk("w9_sum", out_sum9, 388);
`endif
    chk("w9_ovf", out_overflow9, 1);
    release_result();

    for (int i = 1; i <= 4; i++) send(8'(i));
    in_valid   = 1'b1;
    in_product = 8'd99;
    for (int i = 0; i < 3; i++) begin
      chk("hold_sum", out_sum, 10);
      chk("hold_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    release_result();
    chk("rel_valid", out_valid, 0);
    chk("rel_ready", in_ready, 1);
    chk("rel_sum", out_sum, 0);

    send(8'd50);
    send(8'd60);
    clear      = 1'b1;
    in_valid   = 1'b1;
    in_product = 8'd70;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int i = 5; i <= 8; i++) send(8'(i));
    chk("clr_sum", out_sum, 26);
    chk("clr_valid", out_valid, 1);
    release_result();

    send(8'd1);
    send(8'd2);
    #3 rst = 1'b1;
    #1;
    chk("arst_sum", out_sum, 0);
    chk("arst_valid", out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("arst_ready", in_ready, 1);
    send(8'd10);
    send(8'd20);
    send(8'd30);
    send(8'd40);
    chk("f100_sum", out_sum, 100);
    #3 rst = 1'b1;
    #1;
    chk("hrst_valid", out_valid, 0);
    chk("hrst_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    n          = 0;
    cyc        = 0;
    in_product = 8'd9;
    while (n < 4 && cyc < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) n++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("tog_xfers", n, 4);
    chk("tog_sum", out_sum, 36);
    chk("tog_valid", out_valid, 1);
    release_result();

    for (int i = 0; i < 500; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_product = 8'($urandom_range(0, 255));
      clear      = ($urandom_range(0, 15) == 0);
      out_ready  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
